// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the oversampling UART
package uart_pkg;

   // receiver FSM states
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BRK
   } uart_state_e;

   // decoded parity modes
   typedef enum logic [2:0] {
      PM_NONE,
      PM_EVEN,
      PM_ODD,
      PM_MARK,
      PM_SPACE
   } par_mode_e;

   // parity mode names accepted by the PARITY_MODE parameter
   localparam string PAR_NONE  = "none";
   localparam string PAR_EVEN  = "even";
   localparam string PAR_ODD   = "odd";
   localparam string PAR_MARK  = "mark";
   localparam string PAR_SPACE = "space";

   // expected parity bit; data is zero-extended so unused high bits do not disturb the XOR
   function automatic logic parity_expect(input par_mode_e mode, input logic [8:0] data);
      case (mode)
         PM_EVEN: return ^data;
         PM_ODD:  return ~^data;
         PM_MARK: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - received-entry stream with valid/ready handshake
interface uart_rx_os_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx_valid;
   logic                  rx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_parity_err;
   logic                  rx_frame_err;
   logic                  rx_break;

   modport master (
      output rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break,
      input  rx_ready
   );

   modport slave (
      input  rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break,
      output rx_ready
   );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider with synchronous phase restart
module uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   output logic tick_o
);
   localparam int DIV_C = (DIV < 1) ? 1 : DIV;
   localparam int CW    = (DIV_C > 1) ? $clog2(DIV_C) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV_C - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // count 0..DIV-1; restart forces phase 0 on the following cycle
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // divider register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote and output FIFO
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int    CLK_FRE     = 50,
   parameter int    BAUD_RATE   = 115200,
   parameter int    OVERSAMPLE  = 16,
   parameter int    DATA_WIDTH  = 8,
   parameter string PARITY_MODE = "none",
   parameter int    STOP_WIDTH  = 1,
   parameter int    FIFO_DEPTH  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_enable,
   input  logic         rx_pin,
   input  logic         ovr_clr,
   output logic         rx_overrun,
   uart_rx_os_if.master rx_if
);
   localparam int DIV = (CLK_FRE * 1_000_000) / (BAUD_RATE * OVERSAMPLE);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int M   = OVERSAMPLE / 2;
   localparam logic [SW-1:0] T_M1  = SW'(M - 1);
   localparam logic [SW-1:0] T_M   = SW'(M);
   localparam logic [SW-1:0] T_RES = SW'(M + 1);
   localparam logic [SW-1:0] T_END = SW'(OVERSAMPLE - 1);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic LAST_STOP = (STOP_WIDTH > 1);
   localparam par_mode_e PMODE =
      (PARITY_MODE == PAR_EVEN)  ? PM_EVEN  :
      (PARITY_MODE == PAR_ODD)   ? PM_ODD   :
      (PARITY_MODE == PAR_MARK)  ? PM_MARK  :
      (PARITY_MODE == PAR_SPACE) ? PM_SPACE : PM_NONE;
   localparam bit HAS_PAR = (PMODE != PM_NONE);
   localparam int EW   = DATA_WIDTH + 3;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

   // synchroniser and edge detect
   logic [1:0] sync_q;
   logic       rx_prev_q;
   logic       rx_s;

   // receiver state
   uart_state_e           state_q, state_d;
   logic [SW-1:0]         s_cnt_q, s_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  samp_m1_q, samp_m1_d;
   logic                  samp_m_q, samp_m_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  par_bit_q, par_bit_d;
   logic                  par_err_q, par_err_d;
   logic                  frm_err_q, frm_err_d;
   logic                  stop0_q, stop0_d;
   logic                  tick, restart, maj, at_res, at_end;
   logic                  first_stop, is_brk, push;
   logic [EW-1:0]         push_entry;

   // output FIFO
   logic [EW-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            ovr_q, ovr_d;
   logic            valid, pop, full, wr_en;
   logic [EW-1:0]   head;

   assign rx_s = sync_q[1];

   // two-flop synchroniser idling high, plus previous value for falling-edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], rx_pin};
         rx_prev_q <= rx_s;
      end
   end

   assign restart = (state_q == S_IDLE) && (state_d == S_START);

   uart_baud_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk       (clk),
      .rst       (rst),
      .restart_i (restart),
      .tick_o    (tick)
   );

   assign maj    = (samp_m1_q & samp_m_q) | (samp_m1_q & rx_s) | (samp_m_q & rx_s);
   assign at_res = tick && (s_cnt_q == T_RES);
   assign at_end = tick && (s_cnt_q == T_END);

   // next-state logic: sample capture, bit resolution, and frame assembly
   always_comb begin
      state_d    = state_q;
      s_cnt_d    = s_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      samp_m1_d  = samp_m1_q;
      samp_m_d   = samp_m_q;
      shreg_d    = shreg_q;
      par_bit_d  = par_bit_q;
      par_err_d  = par_err_q;
      frm_err_d  = frm_err_q;
      stop0_d    = stop0_q;
      push       = 1'b0;
      first_stop = (stop_cnt_q == 1'b0) ? maj : stop0_q;
      is_brk     = (shreg_q == '0) && !(HAS_PAR && par_bit_q) && !first_stop;
      push_entry = {is_brk, frm_err_q | ~maj, par_err_q & ~is_brk, shreg_q};

      if (tick && (state_q != S_IDLE) && (state_q != S_BRK)) begin
         s_cnt_d = s_cnt_q + 1'b1;
         if (s_cnt_q == T_M1) samp_m1_d = rx_s;
         if (s_cnt_q == T_M)  samp_m_d  = rx_s;
      end

      case (state_q)
         S_IDLE: begin
            s_cnt_d    = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            par_bit_d  = 1'b0;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
            stop0_d    = 1'b0;
            if (rx_enable && rx_prev_q && !rx_s) state_d = S_START;
         end
         S_START: begin
            if (at_res && maj)  state_d = S_IDLE;
            else if (at_end)    state_d = S_DATA;
         end
         S_DATA: begin
            if (at_res) shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
            if (at_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = HAS_PAR ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (at_res) begin
               par_bit_d = maj;
               par_err_d = (maj != parity_expect(PMODE, 9'(shreg_q)));
            end
            if (at_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (at_res) begin
               if (!maj) frm_err_d = 1'b1;
               if (stop_cnt_q == 1'b0) stop0_d = maj;
               if (stop_cnt_q == LAST_STOP) begin
                  push    = 1'b1;
                  state_d = is_brk ? S_BRK : S_IDLE;
               end
            end else if (at_end) begin
               stop_cnt_d = 1'b1;
            end
         end
         S_BRK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // receiver datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         s_cnt_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         samp_m1_q  <= 1'b1;
         samp_m_q   <= 1'b1;
         shreg_q    <= '0;
         par_bit_q  <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         stop0_q    <= 1'b0;
      end else begin
         s_cnt_q    <= s_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         samp_m1_q  <= samp_m1_d;
         samp_m_q   <= samp_m_d;
         shreg_q    <= shreg_d;
         par_bit_q  <= par_bit_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
         stop0_q    <= stop0_d;
      end
   end

   assign valid = (count_q != '0);

   // FIFO control: a push into a full FIFO succeeds only if the head leaves the same cycle
   always_comb begin
      pop      = valid && rx_if.rx_ready;
      full     = (count_q == FULL_CNT);
      wr_en    = push && (!full || pop);
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (!wr_en && pop) count_d = count_q - 1'b1;
      ovr_d = ovr_q;
      if (push && full && !pop) ovr_d = 1'b1;
      else if (ovr_clr)         ovr_d = 1'b0;
   end

   // FIFO pointers, occupancy and sticky overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovr_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovr_q    <= ovr_d;
      end
   end

   // FIFO storage; contents are masked at the output while empty
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_entry;
   end

   assign head                = valid ? mem_q[rd_ptr_q] : '0;
   assign rx_if.rx_valid      = valid;
   assign rx_if.rx_data       = head[DATA_WIDTH-1:0];
   assign rx_if.rx_parity_err = head[DATA_WIDTH];
   assign rx_if.rx_frame_err  = head[DATA_WIDTH+1];
   assign rx_if.rx_break      = head[DATA_WIDTH+2];
   assign rx_overrun          = ovr_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard bench for uart_rx_os across three configurations
module tb_uart_rx_os
   import uart_pkg::*;
;
   localparam int BIT_A = 432;
   localparam int BIT_F = 64;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic ovr_clr;
   logic pin_a, pin_b, pin_c;
   logic ovr_a, ovr_b, ovr_c;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_now = 0;
   int first_valid_cyc = 0;
   bit a_seen = 1'b0;

   logic [11:0] exp_a[$];
   logic [11:0] exp_b[$];
   logic [11:0] exp_c[$];

   uart_rx_os_if #(.DATA_WIDTH(8)) a_if ();
   uart_rx_os_if #(.DATA_WIDTH(8)) b_if ();
   uart_rx_os_if #(.DATA_WIDTH(9)) c_if ();

   uart_rx_os u_a (
      .clk (clk), .rst (rst), .rx_enable (en), .rx_pin (pin_a),
      .ovr_clr (ovr_clr), .rx_overrun (ovr_a), .rx_if (a_if)
   );

   uart_rx_os #(
      .BAUD_RATE (781250), .PARITY_MODE ("even")
   ) u_b (
      .clk (clk), .rst (rst), .rx_enable (en), .rx_pin (pin_b),
      .ovr_clr (ovr_clr), .rx_overrun (ovr_b), .rx_if (b_if)
   );

   uart_rx_os #(
      .BAUD_RATE (781250), .DATA_WIDTH (9), .STOP_WIDTH (2)
   ) u_c (
      .clk (clk), .rst (rst), .rx_enable (en), .rx_pin (pin_c),
      .ovr_clr (ovr_clr), .rx_overrun (ovr_c), .rx_if (c_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_now <= cyc_now + 1;

   always @(negedge clk) begin
      if (a_if.rx_valid && !a_seen) begin
         a_seen = 1'b1;
         first_valid_cyc = cyc_now;
      end
   end

   function automatic logic [11:0] ent(input logic brk, input logic frm, input logic par,
                                       input logic [8:0] d);
      return {brk, frm, par, d};
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic rng(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic unexpected(input string name, input logic [11:0] act);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got unexpected entry 0x%0h expected none", name, act);
   endtask

   task automatic monitor();
      logic [11:0] got;
      forever begin
         @(negedge clk);
         if (a_if.rx_valid && a_if.rx_ready) begin
            got = {a_if.rx_break, a_if.rx_frame_err, a_if.rx_parity_err, 1'b0, a_if.rx_data};
            if (exp_a.size() == 0) unexpected("A_entry", got);
            else cmp("A_entry", 32'(got), 32'(exp_a.pop_front()));
         end
         if (b_if.rx_valid && b_if.rx_ready) begin
            got = {b_if.rx_break, b_if.rx_frame_err, b_if.rx_parity_err, 1'b0, b_if.rx_data};
            if (exp_b.size() == 0) unexpected("B_entry", got);
            else cmp("B_entry", 32'(got), 32'(exp_b.pop_front()));
         end
         if (c_if.rx_valid && c_if.rx_ready) begin
            got = {c_if.rx_break, c_if.rx_frame_err, c_if.rx_parity_err, c_if.rx_data};
            if (exp_c.size() == 0) unexpected("C_entry", got);
            else cmp("C_entry", 32'(got), 32'(exp_c.pop_front()));
         end
      end
   endtask

   task automatic drive(input int inst, input logic v, input int n);
      case (inst)
         0:       pin_a = v;
         1:       pin_b = v;
         default: pin_c = v;
      endcase
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int inst, input logic [8:0] d, input int nbits, input int par,
                       input int nstop, input int bclk);
      drive(inst, 1'b0, bclk);
      for (int i = 0; i < nbits; i++) drive(inst, d[i], bclk);
      if (par >= 0) drive(inst, par[0], bclk);
      for (int i = 0; i < nstop; i++) drive(inst, 1'b1, bclk);
   endtask

   initial begin
      int t0;
      rst = 1'b1; en = 1'b1; ovr_clr = 1'b0;
      pin_a = 1'b1; pin_b = 1'b1; pin_c = 1'b1;
      a_if.rx_ready = 1'b1; b_if.rx_ready = 1'b1; c_if.rx_ready = 1'b1;
      fork
         monitor();
      join_none
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      cmp("reset_A_valid", 32'(a_if.rx_valid), 0);
      cmp("reset_A_data", 32'(a_if.rx_data), 0);
      cmp("reset_A_overrun", 32'(ovr_a), 0);
      cmp("reset_A_state", 32'(u_a.state_q), 32'(S_IDLE));
      cmp("reset_B_valid", 32'(b_if.rx_valid), 0);
      cmp("reset_C_valid", 32'(c_if.rx_valid), 0);

      // 0xA5 8N1 at default rate, with push latency from start edge
      exp_a.push_back(ent(1'b0, 1'b0, 1'b0, 9'h0A5));
      t0 = cyc_now;
      send(0, 9'h0A5, 8, -1, 1, BIT_A);
      rng("A_latency", first_valid_cyc - t0, 4040, 4170);
      drive(0, 1'b1, BIT_A);

      // short low glitch must be rejected
      drive(0, 1'b0, 100);
      drive(0, 1'b1, 1000);
      cmp("glitch_valid", 32'(a_if.rx_valid), 0);
      cmp("glitch_state", 32'(u_a.state_q), 32'(S_IDLE));

      // break: 20 bit times low, then a clean frame
      exp_a.push_back(ent(1'b1, 1'b1, 1'b0, 9'h000));
      drive(0, 1'b0, 20 * BIT_A);
      drive(0, 1'b1, 2 * BIT_A);
      exp_a.push_back(ent(1'b0, 1'b0, 1'b0, 9'h05A));
      send(0, 9'h05A, 8, -1, 1, BIT_A);
      drive(0, 1'b1, BIT_A);

      // overrun: five frames into a four-entry FIFO with the consumer stalled
      a_if.rx_ready = 1'b0;
      for (int k = 1; k <= 4; k++) exp_a.push_back(ent(1'b0, 1'b0, 1'b0, 9'(k)));
      for (int k = 1; k <= 5; k++) send(0, 9'(k), 8, -1, 1, BIT_A);
      @(posedge clk);
      #1;
      cmp("overrun_set", 32'(ovr_a), 1);
      cmp("overrun_valid", 32'(a_if.rx_valid), 1);
      ovr_clr = 1'b1;
      @(posedge clk);
      #1;
      ovr_clr = 1'b0;
      cmp("overrun_clr", 32'(ovr_a), 0);
      a_if.rx_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      cmp("overrun_drained", 32'(a_if.rx_valid), 0);

      // even parity: wrong parity bit then correct parity bit
      exp_b.push_back(ent(1'b0, 1'b0, 1'b1, 9'h003));
      send(1, 9'h003, 8, 1, 1, BIT_F);
      exp_b.push_back(ent(1'b0, 1'b0, 1'b0, 9'h003));
      send(1, 9'h003, 8, 0, 1, BIT_F);
      drive(1, 1'b1, BIT_F);

      // 9-bit, two stop bits, back to back
      exp_c.push_back(ent(1'b0, 1'b0, 1'b0, 9'h1FF));
      exp_c.push_back(ent(1'b0, 1'b0, 1'b0, 9'h100));
      send(2, 9'h1FF, 9, -1, 2, BIT_F);
      send(2, 9'h100, 9, -1, 2, BIT_F);
      drive(2, 1'b1, 2 * BIT_F);

      // reset during a frame discards it
      drive(2, 1'b0, BIT_F);
      drive(2, 1'b1, 3 * BIT_F);
      cmp("midframe_state", 32'(u_c.state_q), 32'(S_DATA));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(2, 1'b1, 14 * BIT_F);
      cmp("midframe_valid", 32'(c_if.rx_valid), 0);
      cmp("midframe_data", 32'(c_if.rx_data), 0);
      cmp("midframe_state_after", 32'(u_c.state_q), 32'(S_IDLE));

      for (int i = 0; i < 3000 && (exp_a.size() + exp_b.size() + exp_c.size()) != 0; i++)
         @(posedge clk);
      cmp("A_queue_empty", 32'(exp_a.size()), 0);
      cmp("B_queue_empty", 32'(exp_b.size()), 0);
      cmp("C_queue_empty", 32'(exp_c.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
